// File: rtl/double_buffer_pkg.sv
// Shared types and constants for the ping-pong buffer controller.
package double_buffer_pkg;

  localparam int NUM_BUF_lp = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FILL  = 2'd2
  } dbuf_wr_state_t;

  function automatic logic [NUM_BUF_lp-1:0] buf_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/double_buffer_rd_tracker.sv
// Read side: follows the pushing buffer, muxes its row onto the array stream
// and counts delivered tiles.
module double_buffer_rd_tracker
  import double_buffer_pkg::*;
#(
  parameter int AXI_DW_g  = 64,
  parameter int TILE_CW_g = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [NUM_BUF_lp-1:0]                pushing_i,
  input  logic [NUM_BUF_lp-1:0][AXI_DW_g-1:0]  buf_data_i,
  output logic                                 rd_sel_o,
  output logic [AXI_DW_g-1:0]                  array_data_o,
  output logic                                 array_valid_o,
  output logic                                 tile_done_o,
  output logic [TILE_CW_g-1:0]                 tiles_o
);

  logic rd_sel, rd_sel_d, push_d, push_dd, push_cur;

  assign push_cur = pushing_i[rd_sel];

  // push_d / rd_sel_d line up with the buffers' one-cycle BRAM read latency.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_sel   <= 1'b0;
      rd_sel_d <= 1'b0;
      push_d   <= 1'b0;
      push_dd  <= 1'b0;
      tiles_o  <= '0;
    end else begin
      push_d   <= push_cur;
      push_dd  <= push_d;
      rd_sel_d <= rd_sel;
      if (push_d && !push_cur)
        rd_sel <= ~rd_sel;
      if (push_dd && !push_d)
        tiles_o <= tiles_o + 1'b1;
    end
  end

  assign rd_sel_o      = rd_sel;
  assign array_valid_o = push_d;
  assign array_data_o  = buf_data_i[rd_sel_d];
  assign tile_done_o   = push_dd & ~push_d;

endmodule

// File: rtl/double_buffer_ctrl.sv
// Ping-pong controller: grants the W stream to two buffers alternately and
// merges their pushed rows into one stream for the systolic array.
module double_buffer_ctrl
  import double_buffer_pkg::*;
#(
  parameter int AXI_DW_g  = 64,
  parameter int depth_g   = 16,
  parameter int TILE_CW_g = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 s_axi_wvalid_i,
  input  logic                                 s_axi_wlast_i,
  output logic                                 s_axi_wready_o,
  output logic [NUM_BUF_lp-1:0]                buf_wvalid_o,
  input  logic [NUM_BUF_lp-1:0]                buf_wready_i,
  output logic [NUM_BUF_lp-1:0]                grant_o,
  input  logic [NUM_BUF_lp-1:0]                available_i,
  input  logic [NUM_BUF_lp-1:0]                pushing_i,
  input  logic [NUM_BUF_lp-1:0][AXI_DW_g-1:0]  buf_data_i,
  output logic [AXI_DW_g-1:0]                  array_data_o,
  output logic                                 array_valid_o,
  output logic                                 tile_done_o,
  output logic [TILE_CW_g-1:0]                 tiles_o,
  output logic                                 proto_err_o
);

  localparam int BCW_lp = $clog2(depth_g) + 1;
  localparam logic [BCW_lp-1:0] LAST_BEAT_lp = BCW_lp'(depth_g - 1);

  dbuf_wr_state_t    state;
  logic              wr_sel;
  logic              rd_sel;
  logic [BCW_lp-1:0] beat_cnt;
  logic              fill, hs, last_beat, wlast_err, push_err;

  assign fill           = (state == FILL);
  assign s_axi_wready_o = fill & buf_wready_i[wr_sel];
  assign hs             = s_axi_wvalid_i & s_axi_wready_o;
  assign last_beat      = (beat_cnt == LAST_BEAT_lp);
  assign wlast_err      = hs & (s_axi_wlast_i != last_beat);
  // Only the buffer the read side is following may push.
  assign push_err       = pushing_i[~rd_sel] & ~pushing_i[rd_sel];

  always_comb begin
    buf_wvalid_o = '0;
    if (fill)
      buf_wvalid_o[wr_sel] = s_axi_wvalid_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      wr_sel   <= 1'b0;
      beat_cnt <= '0;
      grant_o  <= '0;
    end else begin
      grant_o <= '0;
      case (state)
        IDLE: begin
          if (available_i[wr_sel]) begin
            state   <= GRANT;
            grant_o <= buf_onehot(wr_sel);
          end
        end
        GRANT: state <= FILL;
        FILL: begin
          if (hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              wr_sel   <= ~wr_sel;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      proto_err_o <= 1'b0;
    else if (wlast_err || push_err)
      proto_err_o <= 1'b1;
  end

  double_buffer_rd_tracker #(
    .AXI_DW_g  (AXI_DW_g),
    .TILE_CW_g (TILE_CW_g)
  ) u_rd (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pushing_i     (pushing_i),
    .buf_data_i    (buf_data_i),
    .rd_sel_o      (rd_sel),
    .array_data_o  (array_data_o),
    .array_valid_o (array_valid_o),
    .tile_done_o   (tile_done_o),
    .tiles_o       (tiles_o)
  );

endmodule
